// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB/HALT and drives
// every datapath select and strobe; outputs are combinational from state and inputs.
module mips_mc_controller #(
  parameter int unsigned ALUOP_W     = 4,
  parameter bit          MEM_WAIT_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        instr,
  input  logic               mem_ready,
  input  logic               alu_zero,
  input  logic               alu_neg,
  input  logic               rs_is_zero,
  output logic               ir_write,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               imm_zext,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               load_byte,
  output logic               active,
  output logic               illegal
);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

  localparam logic [5:0] OpRtype = 6'h00, OpJ = 6'h02, OpBeq = 6'h04, OpBne = 6'h05;
  localparam logic [5:0] OpBgtz = 6'h07, OpAddiu = 6'h09, OpSlti = 6'h0A, OpAndi = 6'h0C;
  localparam logic [5:0] OpOri = 6'h0D, OpLb = 6'h20, OpLw = 6'h23, OpSw = 6'h2B;
  localparam logic [5:0] FnJr = 6'h08, FnAddu = 6'h21, FnSubu = 6'h23, FnAnd = 6'h24;
  localparam logic [5:0] FnOr = 6'h25, FnSlt = 6'h2A;
  localparam logic [3:0] AluAnd = 4'b0000, AluOr = 4'b0001, AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110, AluSlt = 4'b0111;

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [5:0] opcode, funct;
  logic       ready, op_ok, r_ok;
  logic [3:0] r_op, op4;
  logic       unused_instr;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign ready        = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign unused_instr = ^instr[25:6];
  assign alu_op       = ALUOP_W'(op4);
  assign illegal      = illegal_q;

  always_comb begin
    op_ok = 1'b0;
    case (opcode)
      OpRtype, OpJ, OpBeq, OpBne, OpBgtz, OpAddiu, OpSlti,
      OpAndi, OpOri, OpLb, OpLw, OpSw: op_ok = 1'b1;
      default:                         op_ok = 1'b0;
    endcase
  end

  always_comb begin
    r_ok = 1'b1;
    r_op = AluAdd;
    case (funct)
      FnAddu:  r_op = AluAdd;
      FnSubu:  r_op = AluSub;
      FnAnd:   r_op = AluAnd;
      FnOr:    r_op = AluOr;
      FnSlt:   r_op = AluSlt;
      default: r_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    imm_zext   = 1'b0;
    op4        = AluAnd;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    load_byte  = 1'b0;
    active     = 1'b1;
    unique case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        op4       = AluAdd;
        if (ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        // Branch target is computed here and parked in ALUOut.
        alu_src_b = 2'b11;
        op4       = AluAdd;
        if (op_ok) begin
          state_d = StExec;
        end else begin
          state_d   = StHalt;
          illegal_d = 1'b1;
        end
      end
      StExec: begin
        case (opcode)
          OpRtype: begin
            if (funct == FnJr) begin
              pc_write = 1'b1;
              pc_src   = 2'b11;
              state_d  = rs_is_zero ? StHalt : StFetch;
            end else if (r_ok) begin
              alu_src_a = 1'b1;
              op4       = r_op;
              state_d   = StWb;
            end else begin
              state_d   = StHalt;
              illegal_d = 1'b1;
            end
          end
          OpLb, OpLw, OpSw: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            op4       = AluAdd;
            state_d   = StMem;
          end
          OpAddiu, OpSlti, OpAndi, OpOri: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            imm_zext  = (opcode == OpAndi) || (opcode == OpOri);
            op4       = (opcode == OpAddiu) ? AluAdd :
                        (opcode == OpSlti)  ? AluSlt :
                        (opcode == OpAndi)  ? AluAnd : AluOr;
            state_d   = StWb;
          end
          OpBeq, OpBne, OpBgtz: begin
            alu_src_a = 1'b1;
            op4       = AluSub;
            pc_src    = 2'b01;
            pc_write  = (opcode == OpBeq) ? alu_zero :
                        (opcode == OpBne) ? !alu_zero : (!alu_zero && !alu_neg);
            state_d   = StFetch;
          end
          OpJ: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            state_d  = StFetch;
          end
          default: begin
            state_d   = StHalt;
            illegal_d = 1'b1;
          end
        endcase
      end
      StMem: begin
        iord = 1'b1;
        if (opcode == OpSw) begin
          mem_write = 1'b1;
          if (ready) state_d = StFetch;
        end else begin
          mem_read = 1'b1;
          if (ready) state_d = StWb;
        end
      end
      StWb: begin
        reg_write = 1'b1;
        if (opcode == OpLw || opcode == OpLb) begin
          mem_to_reg = 1'b1;
          load_byte  = (opcode == OpLb);
        end else begin
          reg_dst = (opcode == OpRtype);
        end
        state_d = StFetch;
      end
      StHalt: active = 1'b0;
      default: state_d = StFetch;
    endcase
    // Reset forces every output low immediately, aborting any in-flight strobe.
    if (!rst_n) begin
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      imm_zext   = 1'b0;
      op4        = AluAnd;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      load_byte  = 1'b0;
      active     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: per-cycle expected output vectors pass through a
// scoreboard queue and are checked with immediate assertions.
module tb_mips_mc_controller;

  typedef struct packed {
    logic       ir_write, iord, mem_read, mem_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [3:0] alu_op;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write, reg_dst, mem_to_reg, load_byte, active, illegal;
  } ov_t;

  localparam logic [3:0] AluAnd = 4'b0000, AluAdd = 4'b0010, AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic mem_ready = 1'b0, alu_zero = 1'b0, alu_neg = 1'b0, rs_is_zero = 1'b0;

  logic ir_write, iord, mem_read, mem_write, alu_src_a, imm_zext, pc_write;
  logic reg_write, reg_dst, mem_to_reg, load_byte, active, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] alu_op;

  logic ir_write2, iord2, mem_read2, mem_write2, alu_src_a2, imm_zext2, pc_write2;
  logic reg_write2, reg_dst2, mem_to_reg2, load_byte2, active2, illegal2;
  logic [1:0] alu_src_b2, pc_src2;
  logic [5:0] alu_op2;

  ov_t obs, obs2;
  ov_t exp_q[$];
  int  n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  mips_mc_controller #(.ALUOP_W(4), .MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .alu_zero(alu_zero),
    .alu_neg(alu_neg), .rs_is_zero(rs_is_zero), .ir_write(ir_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_zext(imm_zext), .alu_op(alu_op), .pc_write(pc_write),
    .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .load_byte(load_byte), .active(active), .illegal(illegal)
  );

  // No-wait build with mem_ready tied low, always running an SW.
  mips_mc_controller #(.ALUOP_W(6), .MEM_WAIT_EN(1'b0)) dut_nw (
    .clk(clk), .rst_n(rst_n), .instr(32'hAC82_0004), .mem_ready(1'b0), .alu_zero(1'b0),
    .alu_neg(1'b0), .rs_is_zero(1'b0), .ir_write(ir_write2), .iord(iord2),
    .mem_read(mem_read2), .mem_write(mem_write2), .alu_src_a(alu_src_a2),
    .alu_src_b(alu_src_b2), .imm_zext(imm_zext2), .alu_op(alu_op2), .pc_write(pc_write2),
    .pc_src(pc_src2), .reg_write(reg_write2), .reg_dst(reg_dst2), .mem_to_reg(mem_to_reg2),
    .load_byte(load_byte2), .active(active2), .illegal(illegal2)
  );

  assign obs  = {ir_write, iord, mem_read, mem_write, alu_src_a, alu_src_b, imm_zext, alu_op,
                 pc_write, pc_src, reg_write, reg_dst, mem_to_reg, load_byte, active, illegal};
  assign obs2 = {ir_write2, iord2, mem_read2, mem_write2, alu_src_a2, alu_src_b2, imm_zext2,
                 alu_op2[3:0], pc_write2, pc_src2, reg_write2, reg_dst2, mem_to_reg2,
                 load_byte2, active2, illegal2};

  function automatic ov_t e_base();
    ov_t e = '0;
    e.active = 1'b1;
    return e;
  endfunction

  function automatic ov_t e_fetch(logic rdy);
    ov_t e = e_base();
    e.mem_read  = 1'b1;
    e.alu_src_b = 2'b01;
    e.alu_op    = AluAdd;
    e.ir_write  = rdy;
    e.pc_write  = rdy;
    return e;
  endfunction

  function automatic ov_t e_decode();
    ov_t e = e_base();
    e.alu_src_b = 2'b11;
    e.alu_op    = AluAdd;
    return e;
  endfunction

  function automatic ov_t e_exec(logic a, logic [1:0] b, logic [3:0] op, logic zext);
    ov_t e = e_base();
    e.alu_src_a = a;
    e.alu_src_b = b;
    e.alu_op    = op;
    e.imm_zext  = zext;
    return e;
  endfunction

  function automatic ov_t e_br(logic pcw);
    ov_t e = e_exec(1'b1, 2'b00, AluSub, 1'b0);
    e.pc_src   = 2'b01;
    e.pc_write = pcw;
    return e;
  endfunction

  function automatic ov_t e_jump(logic [1:0] src);
    ov_t e = e_base();
    e.pc_write = 1'b1;
    e.pc_src   = src;
    return e;
  endfunction

  function automatic ov_t e_mem(logic wr);
    ov_t e = e_base();
    e.iord      = 1'b1;
    e.mem_write = wr;
    e.mem_read  = !wr;
    return e;
  endfunction

  function automatic ov_t e_wb(logic dst, logic m2r, logic lb);
    ov_t e = e_base();
    e.reg_write  = 1'b1;
    e.reg_dst    = dst;
    e.mem_to_reg = m2r;
    e.load_byte  = lb;
    return e;
  endfunction

  function automatic ov_t e_halt(logic ill);
    ov_t e = '0;
    e.illegal = ill;
    return e;
  endfunction

  task automatic compare(input logic which, input string tag);
    ov_t got, ev;
    got = which ? obs2 : obs;
    ev  = exp_q.pop_front();
    n_tests++;
    assert (got === ev) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, ev);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then check outputs 1ns later.
  task automatic step(input logic which, input logic [31:0] ins, input logic rdy,
                      input logic z, input logic n, input logic rsz, input ov_t e,
                      input string tag);
    @(negedge clk);
    instr      = ins;
    mem_ready  = rdy;
    alu_zero   = z;
    alu_neg    = n;
    rs_is_zero = rsz;
    exp_q.push_back(e);
    #1;
    compare(which, tag);
  endtask

  task automatic s(input logic [31:0] ins, input logic rdy, input ov_t e, input string tag);
    step(1'b0, ins, rdy, 1'b0, 1'b0, 1'b0, e, tag);
  endtask

  // Asserts reset mid-cycle, checks outputs drop at once, holds 2 edges, releases.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    exp_q.push_back(ov_t'(0));
    #1;
    compare(1'b0, tag);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  localparam logic [31:0] IAddu = 32'h0085_1021, ILw = 32'h8C82_0004, ILb = 32'h8082_0004;
  localparam logic [31:0] IAndi = 32'h3082_000F, ISlti = 32'h2882_000F, IBeq = 32'h1085_0003;
  localparam logic [31:0] IBne = 32'h1485_0003, IBgtz = 32'h1C80_0003, IJ = 32'h0800_0010;
  localparam logic [31:0] ISubu = 32'h0085_1023, ISw = 32'hAC82_0004, IJr = 32'h0000_0008;
  localparam logic [31:0] IBad = 32'hFC00_0000, IBadFn = 32'h0000_003F;

  initial begin
    do_reset("reset_outputs_zero");

    s(IAddu, 1'b1, e_fetch(1'b1), "addu_fetch");
    s(IAddu, 1'b1, e_decode(), "addu_decode");
    s(IAddu, 1'b1, e_exec(1'b1, 2'b00, AluAdd, 1'b0), "addu_exec");
    s(IAddu, 1'b1, e_wb(1'b1, 1'b0, 1'b0), "addu_wb");

    for (int i = 0; i < 3; i++) s(ILw, 1'b0, e_fetch(1'b0), "lw_fetch_wait");
    s(ILw, 1'b1, e_fetch(1'b1), "lw_fetch_ready");
    s(ILw, 1'b1, e_decode(), "lw_decode");
    s(ILw, 1'b1, e_exec(1'b1, 2'b10, AluAdd, 1'b0), "lw_exec");
    for (int i = 0; i < 2; i++) s(ILw, 1'b0, e_mem(1'b0), "lw_mem_wait");
    s(ILw, 1'b1, e_mem(1'b0), "lw_mem_ready");
    s(ILw, 1'b1, e_wb(1'b0, 1'b1, 1'b0), "lw_wb");

    s(ILb, 1'b1, e_fetch(1'b1), "lb_fetch");
    s(ILb, 1'b1, e_decode(), "lb_decode");
    s(ILb, 1'b1, e_exec(1'b1, 2'b10, AluAdd, 1'b0), "lb_exec");
    s(ILb, 1'b1, e_mem(1'b0), "lb_mem");
    s(ILb, 1'b1, e_wb(1'b0, 1'b1, 1'b1), "lb_wb");

    s(IAndi, 1'b1, e_fetch(1'b1), "andi_fetch");
    s(IAndi, 1'b1, e_decode(), "andi_decode");
    s(IAndi, 1'b1, e_exec(1'b1, 2'b10, AluAnd, 1'b1), "andi_exec");
    s(IAndi, 1'b1, e_wb(1'b0, 1'b0, 1'b0), "andi_wb");

    s(ISlti, 1'b1, e_fetch(1'b1), "slti_fetch");
    s(ISlti, 1'b1, e_decode(), "slti_decode");
    s(ISlti, 1'b1, e_exec(1'b1, 2'b10, AluSlt, 1'b0), "slti_exec");
    s(ISlti, 1'b1, e_wb(1'b0, 1'b0, 1'b0), "slti_wb");

    s(IBeq, 1'b1, e_fetch(1'b1), "beq_fetch");
    s(IBeq, 1'b1, e_decode(), "beq_decode");
    step(1'b0, IBeq, 1'b1, 1'b1, 1'b0, 1'b0, e_br(1'b1), "beq_taken");
    s(IBne, 1'b1, e_fetch(1'b1), "bne_fetch");
    s(IBne, 1'b1, e_decode(), "bne_decode");
    step(1'b0, IBne, 1'b1, 1'b1, 1'b0, 1'b0, e_br(1'b0), "bne_not_taken");
    s(IBgtz, 1'b1, e_fetch(1'b1), "bgtz_fetch");
    s(IBgtz, 1'b1, e_decode(), "bgtz_decode");
    step(1'b0, IBgtz, 1'b1, 1'b0, 1'b1, 1'b0, e_br(1'b0), "bgtz_neg");
    s(IBgtz, 1'b1, e_fetch(1'b1), "bgtz2_fetch");
    s(IBgtz, 1'b1, e_decode(), "bgtz2_decode");
    step(1'b0, IBgtz, 1'b1, 1'b0, 1'b0, 1'b0, e_br(1'b1), "bgtz_pos");

    s(IJ, 1'b1, e_fetch(1'b1), "j_fetch");
    s(IJ, 1'b1, e_decode(), "j_decode");
    s(IJ, 1'b1, e_jump(2'b10), "j_exec");

    s(ISubu, 1'b1, e_fetch(1'b1), "subu_fetch");
    s(ISubu, 1'b1, e_decode(), "subu_decode");
    s(ISubu, 1'b1, e_exec(1'b1, 2'b00, AluSub, 1'b0), "subu_exec");
    s(ISubu, 1'b1, e_wb(1'b1, 1'b0, 1'b0), "subu_wb");

    s(ISw, 1'b1, e_fetch(1'b1), "sw_fetch");
    s(ISw, 1'b1, e_decode(), "sw_decode");
    s(ISw, 1'b0, e_exec(1'b1, 2'b10, AluAdd, 1'b0), "sw_exec");
    s(ISw, 1'b0, e_mem(1'b1), "sw_mem_wait1");
    s(ISw, 1'b0, e_mem(1'b1), "sw_mem_wait2");
    do_reset("sw_reset_drop");
    s(ISw, 1'b0, e_fetch(1'b0), "post_reset_fetch");

    s(IJr, 1'b1, e_fetch(1'b1), "jr_fetch");
    s(IJr, 1'b1, e_decode(), "jr_decode");
    step(1'b0, IJr, 1'b1, 1'b0, 1'b0, 1'b1, e_jump(2'b11), "jr_exec");
    for (int i = 0; i < 20; i++) s(IJr, 1'b1, e_halt(1'b0), "jr_halt");

    do_reset("reset_after_jr");
    s(IBad, 1'b1, e_fetch(1'b1), "bad_op_fetch");
    s(IBad, 1'b1, e_decode(), "bad_op_decode");
    s(IBad, 1'b1, e_halt(1'b1), "bad_op_halt");
    s(IAddu, 1'b1, e_halt(1'b1), "bad_op_sticky");

    do_reset("reset_after_bad_op");
    s(IBadFn, 1'b1, e_fetch(1'b1), "bad_fn_fetch");
    s(IBadFn, 1'b1, e_decode(), "bad_fn_decode");
    s(IBadFn, 1'b1, e_base(), "bad_fn_exec");
    s(IBadFn, 1'b1, e_halt(1'b1), "bad_fn_halt");

    do_reset("reset_before_nowait");
    step(1'b1, IAddu, 1'b0, 1'b0, 1'b0, 1'b0, e_fetch(1'b1), "nw_fetch");
    step(1'b1, IAddu, 1'b0, 1'b0, 1'b0, 1'b0, e_decode(), "nw_decode");
    n_tests++;
    assert (alu_op2[5:4] === 2'b00) else begin
      n_fail++;
      $error("FAIL nw_aluop_upper: observed %b expected 00", alu_op2[5:4]);
    end
    step(1'b1, IAddu, 1'b0, 1'b0, 1'b0, 1'b0, e_exec(1'b1, 2'b10, AluAdd, 1'b0), "nw_exec");
    step(1'b1, IAddu, 1'b0, 1'b0, 1'b0, 1'b0, e_mem(1'b1), "nw_mem");
    step(1'b1, IAddu, 1'b0, 1'b0, 1'b0, 1'b0, e_fetch(1'b1), "nw_next_fetch");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
